// File: rtl/bldc_pkg.sv
// Shared definitions for the BLDC controller datapath.
//   DATA_W : default operand/result width for the arithmetic blocks
//   data_t : one DATA_W-bit data word
package bldc_pkg;

  localparam int DATA_W = 9;

  typedef logic [DATA_W-1:0] data_t;

endpackage : bldc_pkg

// File: rtl/sub9bit_core.sv
// Combinational ripple-carry adder: {c_out, r} = a + beff + ci.
// Ports:
//   a, beff  : WIDTH-bit operands (beff is already inverted for subtraction)
//   ci       : carry-in into bit 0
//   r        : WIDTH-bit sum
//   c_msb_in : carry into the most significant bit (used for overflow)
//   c_out    : carry out of the most significant bit
module sub9bit_core
  import bldc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] beff,
  input  logic             ci,
  output logic [WIDTH-1:0] r,
  output logic             c_msb_in,
  output logic             c_out
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign r[i]   = a[i] ^ beff[i] ^ c[i];
    assign c[i+1] = (a[i] & beff[i]) | (c[i] & (a[i] ^ beff[i]));
  end

  assign c_msb_in = c[WIDTH-1];
  assign c_out    = c[WIDTH];

endmodule : sub9bit_core

// File: rtl/sub9bit.sv
// Registered WIDTH-bit two's-complement adder/subtractor (ADSU-style).
//   ADD=1 : S = A + B + CI, CO = carry-out
//   ADD=0 : S = A - B - ~CI, CI/CO are active-low borrow-in/borrow-out
//   OFL   : signed overflow, carry into MSB xor carry out of MSB
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_vld     : operands valid this cycle (capture enable)
//   A, B       : operands
//   CI, ADD    : carry/borrow-in, mode select
//   S, CO, OFL : registered result, carry/borrow-out, overflow
//   out_vld    : S/CO/OFL were loaded by the previous cycle's in_vld
// Handshake: valid-only, no ready. A set of operands is taken on every rising
// edge where in_vld=1 and rst=0; its result is presented one cycle later with
// out_vld=1 for exactly that cycle. Without in_vld the result registers hold.
module sub9bit
  import bldc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             ADD,
  output logic [WIDTH-1:0] S,
  output logic             CO,
  output logic             OFL,
  output logic             out_vld
);

  logic [WIDTH-1:0] beff;
  logic [WIDTH-1:0] r;
  logic             c_msb_in;
  logic             c_out;

  // Subtraction is A + ~B + CI, so CI=1 means "no borrow in".
  assign beff = ADD ? B : ~B;

  sub9bit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (A),
    .beff     (beff),
    .ci       (CI),
    .r        (r),
    .c_msb_in (c_msb_in),
    .c_out    (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      S       <= '0;
      CO      <= 1'b0;
      OFL     <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        S   <= r;
        CO  <= c_out;
        OFL <= c_msb_in ^ c_out;
      end
    end
  end

endmodule : sub9bit

// File: tb/tb_sub9bit.sv
module tb_sub9bit;

  localparam int W = 9;

  logic         clk;
  logic         rst;
  logic         in_vld;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ci;
  logic         add;
  logic [W-1:0] s;
  logic         co;
  logic         ofl;
  logic         out_vld;

  int total = 0;
  int bad   = 0;

  // Expected outputs after the next edge, packed as {out_vld, co, ofl, s}.
  logic [W+2:0] exp_q[$];
  string        tag_q[$];

  // Bench-side copy of the held result, for cycles without in_vld.
  logic [W-1:0] hold_s;
  logic         hold_co;
  logic         hold_ofl;

  sub9bit #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .A       (a),
    .B       (b),
    .CI      (ci),
    .ADD     (add),
    .S       (s),
    .CO      (co),
    .OFL     (ofl),
    .out_vld (out_vld)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst    = 1'b1;
    in_vld = 1'b0;
    a      = '0;
    b      = '0;
    ci     = 1'b0;
    add    = 1'b0;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {co, s} = A + (ADD ? B : ~B) + CI at W+1 bits.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                       input logic madd, output logic [W-1:0] ms, output logic mco,
                       output logic mofl);
    logic [W-1:0] be;
    logic [W:0]   sum;
    be   = madd ? mb : ~mb;
    sum  = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, mci};
    ms   = sum[W-1:0];
    mco  = sum[W];
    mofl = (ma[W-1] == be[W-1]) && (sum[W-1] != ma[W-1]);
  endtask

  // ---------------- driver ----------------
  // One cycle: at the falling edge, check what the previous drive produced,
  // then apply new inputs and queue the outputs expected after the next edge.
  task automatic tick(input logic t_rst, input logic t_vld, input logic [W-1:0] t_a,
                      input logic [W-1:0] t_b, input logic t_ci, input logic t_add,
                      input logic [W-1:0] e_s, input logic e_co, input logic e_ofl,
                      input logic e_vld, input string tag);
    logic [W+2:0] e;
    string        t;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".vld"}, {15'd0, out_vld}, {15'd0, e[W+2]});
      check({t, ".co"},  {15'd0, co},      {15'd0, e[W+1]});
      check({t, ".ofl"}, {15'd0, ofl},     {15'd0, e[W]});
      check({t, ".s"},   {7'd0, s},        {7'd0, e[W-1:0]});
    end
    rst    = t_rst;
    in_vld = t_vld;
    a      = t_a;
    b      = t_b;
    ci     = t_ci;
    add    = t_add;
    exp_q.push_back({e_vld, e_co, e_ofl, e_s});
    tag_q.push_back(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ms;
    logic         mco;
    logic         mofl;
    logic         v;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rci;
    logic         radd;

    // Reset for two cycles: everything zero.
    tick(1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 0, 0, 0, "rst0");
    tick(1, 0, 9'h000, 9'h000, 0, 0, 9'h000, 0, 0, 0, "rst1");

    // Back-to-back directed vectors, each result one cycle later in order.
    tick(0, 1, 9'd5,   9'd9,   1, 0, 9'h1FC, 0, 0, 1, "sub_5_9");
    tick(0, 1, 9'h1FF, 9'h001, 0, 1, 9'h000, 1, 0, 1, "add_1ff_1");
    tick(0, 1, 9'h0FF, 9'h001, 0, 1, 9'h100, 0, 1, 1, "add_0ff_1");
    tick(0, 1, 9'h100, 9'h001, 1, 0, 9'h0FF, 1, 1, 1, "sub_100_1");
    tick(0, 1, 9'd9,   9'd5,   0, 0, 9'h003, 1, 0, 1, "sub_9_5_bi");

    // Drop in_vld: result holds, out_vld falls (inputs are garbage).
    tick(0, 0, 9'h1AA, 9'h055, 1, 1, 9'h003, 1, 0, 0, "hold0");
    tick(0, 0, 9'h0F0, 9'h10F, 0, 0, 9'h003, 1, 0, 0, "hold1");

    // Isolated single transaction, then reset coinciding with in_vld.
    tick(0, 1, 9'd5,   9'd9,   1, 0, 9'h1FC, 0, 0, 1, "sub_5_9_b");
    tick(1, 1, 9'd5,   9'd9,   1, 0, 9'h000, 0, 0, 0, "rst_mid");
    tick(0, 0, 9'h000, 9'h000, 0, 0, 9'h000, 0, 0, 0, "post_rst");

    // Random sweep against the reference model, with random valid gaps.
    hold_s   = '0;
    hold_co  = 1'b0;
    hold_ofl = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ra   = W'($urandom_range(0, (1 << W) - 1));
      rb   = W'($urandom_range(0, (1 << W) - 1));
      rci  = 1'($urandom_range(0, 1));
      radd = 1'($urandom_range(0, 1));
      if (v) begin
        model(ra, rb, rci, radd, ms, mco, mofl);
        hold_s   = ms;
        hold_co  = mco;
        hold_ofl = mofl;
      end
      tick(0, v, ra, rb, rci, radd, hold_s, hold_co, hold_ofl, v, "rand");
    end

    // Flush the last queued expectation.
    tick(0, 0, 9'h000, 9'h000, 0, 0, hold_s, hold_co, hold_ofl, 0, "flush");
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [W+2:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".vld"}, {15'd0, out_vld}, {15'd0, e[W+2]});
      check({t, ".s"},   {7'd0, s},        {7'd0, e[W-1:0]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sub9bit
